// File: rtl/l2_req_mux_if.sv
// Shared types and the bundled handshake/bus interface for l2_req_mux.
// The master side is the arbiter, the cores and L2. The slave side is the mux itself.
package attrs;
    localparam int N_CORES = 4;
    typedef logic [$clog2(N_CORES)-1:0] core_id_t;
endpackage

interface l2_req_mux_if #(
    parameter int N_CORES = attrs::N_CORES,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int ID_W = $clog2(N_CORES);

    // Arbiter handshake
    logic [ID_W-1:0]                grant;
    logic                           grant_ready;
    logic                           busy;

    // Per-core ports
    logic [N_CORES-1:0]             core_req;
    logic [N_CORES-1:0]             core_we;
    logic [N_CORES-1:0][ADDR_W-1:0] core_addr;
    logic [N_CORES-1:0][DATA_W-1:0] core_wdata;
    logic [N_CORES-1:0]             core_done;
    logic [N_CORES-1:0]             core_err;
    logic [DATA_W-1:0]              core_rdata;

    // Shared L2 port
    logic                           l2_req;
    logic                           l2_we;
    logic [ADDR_W-1:0]              l2_addr;
    logic [DATA_W-1:0]              l2_wdata;
    logic                           l2_ack;
    logic [DATA_W-1:0]              l2_rdata;

    modport master (
        output grant, grant_ready, core_req, core_we, core_addr, core_wdata, l2_ack, l2_rdata,
        input  busy, core_done, core_err, core_rdata, l2_req, l2_we, l2_addr, l2_wdata
    );

    modport slave (
        input  grant, grant_ready, core_req, core_we, core_addr, core_wdata, l2_ack, l2_rdata,
        output busy, core_done, core_err, core_rdata, l2_req, l2_we, l2_addr, l2_wdata
    );
endinterface

// File: rtl/l2_req_mux.sv
// L2 request mux: services one arbiter grant at a time, runs a single L2 transaction and returns done/data to the owner.
// Optional L2 ack watchdog enabled by defining L2_TIMEOUT_EN.
module l2_req_mux #(
    parameter int N_CORES        = attrs::N_CORES,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    l2_req_mux_if.slave bus
);
    localparam int ID_W = $clog2(N_CORES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_DROP} state_t;

    state_t              state;
    logic [ID_W-1:0]     cur_id;
    logic                l2_req_q;
    logic                l2_we_q;
    logic [ADDR_W-1:0]   l2_addr_q;
    logic [DATA_W-1:0]   l2_wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [N_CORES-1:0]  done_q;
    logic [N_CORES-1:0]  owner_onehot;

    assign owner_onehot = N_CORES'(1) << cur_id;

`ifdef L2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    wait_cnt;
    logic [N_CORES-1:0]  err_q;
`endif

    // NOTE: all state and output registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_id     <= '0;
            l2_req_q   <= 1'b0;
            l2_we_q    <= 1'b0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
`ifdef L2_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle, so they only need setting on the
            // one transition that raises them.
            done_q <= '0;
`ifdef L2_TIMEOUT_EN
            err_q  <= '0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (bus.grant_ready) begin
                        cur_id <= bus.grant;
                        if (bus.core_req[bus.grant]) begin
                            l2_we_q    <= bus.core_we[bus.grant];
                            l2_addr_q  <= bus.core_addr[bus.grant];
                            l2_wdata_q <= bus.core_wdata[bus.grant];
                            l2_req_q   <= 1'b1;
`ifdef L2_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                            state      <= S_ISSUE;
                        end else begin
                            // The grant went stale. Still hold busy for one cycle so the arbiter handshake completes.
                            state <= S_DROP;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.l2_ack) begin
                        l2_req_q <= 1'b0;
                        if (!l2_we_q) begin
                            rdata_q <= bus.l2_rdata;
                        end
                        done_q <= owner_onehot;
                        state  <= S_RESP;
                    end
`ifdef L2_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        l2_req_q <= 1'b0;
                        rdata_q  <= '0;
                        done_q   <= owner_onehot;
                        err_q    <= owner_onehot;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                S_RESP:  state <= S_IDLE;
                S_DROP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.l2_req     = l2_req_q;
    assign bus.l2_we      = l2_we_q;
    assign bus.l2_addr    = l2_addr_q;
    assign bus.l2_wdata   = l2_wdata_q;
    assign bus.core_rdata = rdata_q;
    assign bus.core_done  = done_q;
`ifdef L2_TIMEOUT_EN
    assign bus.core_err   = err_q;
`else
    assign bus.core_err   = '0;
`endif

endmodule

// File: tb/tb_l2_req_mux.sv
// Self-checking bench for l2_req_mux: directed and randomized transactions against a transaction-level model.
// The timeout scenario runs only when L2_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_l2_req_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_req_mux_if #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    l2_req_mux #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_rdata = '0;   // model: last word handed back on the shared read bus

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol guard: the arbiter must never pulse grant_ready while the mux is busy.
    always @(posedge clk) begin
        if (!rst && bus.grant_ready === 1'b1) begin
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL grant_while_busy: busy=%b required 0", bus.busy);
            end
        end
    end

    // At most one core sees done at any time.
    always @(negedge clk) begin
        if (!rst && !$onehot0(bus.core_done)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_onehot: core_done=%b", bus.core_done);
        end
    end

    // One grant from the arbiter for core id. The model predicts when l2_req is high,
    // which values sit on the L2 port, and the done/err/rdata that go back to the core.
    task automatic run_txn(input int id, input bit valid, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int delay, input logic [DW-1:0] rd,
                           input string tag);
        logic [N-1:0] onehot;
        onehot = N'(1) << id;
        bus.core_req[id]   = valid;
        bus.core_we[id]    = we;
        bus.core_addr[id]  = addr;
        bus.core_wdata[id] = wdata;
        bus.grant          = 2'(id);
        bus.grant_ready    = 1'b1;
        tick();
        bus.grant_ready    = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_rise: got %b required 1", tag, bus.busy);
        end
        if (valid) begin
            for (int k = 0; k < delay; k++) begin
                n_cmp++;
                if ({bus.l2_req, bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.core_done} !==
                    {1'b1, we, addr, wdata, N'(0)}) begin
                    n_bad++;
                    $display("FAIL %s l2_issue[%0d]: got req=%b we=%b addr=%h wdata=%h done=%b required req=1 we=%b addr=%h wdata=%h done=0",
                             tag, k, bus.l2_req, bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.core_done, we, addr, wdata);
                end
                if (k == delay - 1) begin
                    bus.l2_ack   = 1'b1;
                    bus.l2_rdata = rd;
                end
                tick();
                bus.l2_ack   = 1'b0;
                bus.l2_rdata = $urandom;
            end
            if (!we) exp_rdata = rd;
            n_cmp++;
            if ({bus.core_done, bus.core_err, bus.core_rdata, bus.busy, bus.l2_req} !==
                {onehot, N'(0), exp_rdata, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL %s response: got done=%b err=%b rdata=%h busy=%b req=%b required done=%b err=0 rdata=%h busy=1 req=0",
                         tag, bus.core_done, bus.core_err, bus.core_rdata, bus.busy, bus.l2_req, onehot, exp_rdata);
            end
            bus.core_req[id] = 1'b0;
            tick();
        end else begin
            n_cmp++;
            if ({bus.l2_req, bus.core_done} !== {1'b0, N'(0)}) begin
                n_bad++;
                $display("FAIL %s stale_grant: got req=%b done=%b required req=0 done=0", tag, bus.l2_req, bus.core_done);
            end
            tick();
        end
        n_cmp++;
        if ({bus.busy, bus.core_done, bus.l2_req} !== {1'b0, N'(0), 1'b0}) begin
            n_bad++;
            $display("FAIL %s back_idle: got busy=%b done=%b req=%b required all 0", tag, bus.busy, bus.core_done, bus.l2_req);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.grant       = '0;
        bus.grant_ready = 1'b1;
        bus.core_req    = '1;
        bus.core_we     = '0;
        bus.core_addr   = '0;
        bus.core_wdata  = '0;
        bus.l2_ack      = 1'b0;
        bus.l2_rdata    = '0;
        tick();
        tick();
        n_cmp++;
        if ({bus.busy, bus.l2_req, bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.core_done, bus.core_err, bus.core_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b req=%b we=%b addr=%h wdata=%h done=%b err=%b rdata=%h required all 0",
                     bus.busy, bus.l2_req, bus.l2_we, bus.l2_addr, bus.l2_wdata, bus.core_done, bus.core_err, bus.core_rdata);
        end
        bus.grant_ready = 1'b0;
        bus.core_req    = '0;
        rst             = 1'b0;
        tick();
    endtask

    task automatic test_read();
        run_txn(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, "read");
    endtask

    task automatic test_write();
        // A write must leave the shared read bus holding the previous read word.
        run_txn(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 32'hFFFF_0000, "write");
    endtask

    task automatic test_stale_grant();
        run_txn(2, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h0, "stale");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            int id;
            id = $urandom_range(N - 1);
            for (int c = 0; c < N; c++) begin
                if (c != id) begin
                    bus.core_we[c]    = 1'($urandom);
                    bus.core_addr[c]  = $urandom;
                    bus.core_wdata[c] = $urandom;
                end
            end
            run_txn(id, ($urandom_range(9) != 0), 1'($urandom), $urandom, $urandom,
                    $urandom_range(1, 4), $urandom, "b2b");
        end
    endtask

    // Round-robin arbiter model with every core requesting: service order 0,1,2,3,0.
    task automatic test_arbiter_loop();
        int order[5] = '{0, 1, 2, 3, 0};
        int last = N - 1;
        bus.core_req = '1;
        for (int i = 0; i < 5; i++) begin
            int g;
            int req_c;
            bit found;
            logic [N-1:0] seen;
            g = last;
            found = 1'b0;
            for (int s = 1; s <= N; s++) begin
                if (!found && bus.core_req[(last + s) % N]) begin
                    g = (last + s) % N;
                    found = 1'b1;
                end
            end
            bus.core_we[g]    = 1'($urandom);
            bus.core_addr[g]  = $urandom;
            bus.core_wdata[g] = $urandom;
            bus.grant         = 2'(g);
            bus.grant_ready   = 1'b1;
            tick();
            bus.grant_ready   = 1'b0;
            seen  = '0;
            req_c = 0;
            for (int w = 0; w < 20 && seen == '0; w++) begin
                if (bus.l2_req === 1'b1) req_c++;
                bus.l2_ack   = (req_c == 2);
                bus.l2_rdata = $urandom;
                if (bus.l2_ack && !bus.core_we[g]) exp_rdata = bus.l2_rdata;
                tick();
                bus.l2_ack = 1'b0;
                seen = bus.core_done;
            end
            n_cmp++;
            if ({seen, bus.core_rdata} !== {N'(1) << order[i], exp_rdata}) begin
                n_bad++;
                $display("FAIL arb_order[%0d]: got done=%b rdata=%h required done=%b rdata=%h",
                         i, seen, bus.core_rdata, N'(1) << order[i], exp_rdata);
            end
            bus.core_req[g] = 1'b0;
            tick();
            bus.core_req[g] = 1'b1;
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL arb_overlap[%0d]: busy=%b required 0", i, bus.busy);
            end
            last = g;
        end
        bus.core_req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.core_req[3]   = 1'b1;
        bus.core_we[3]    = 1'b0;
        bus.core_addr[3]  = 32'h0000_0300;
        bus.grant         = 2'd3;
        bus.grant_ready   = 1'b1;
        tick();
        bus.grant_ready   = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        exp_rdata = '0;
        n_cmp++;
        if ({bus.l2_req, bus.busy, bus.l2_addr, bus.core_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid: got req=%b busy=%b addr=%h rdata=%h required all 0",
                     bus.l2_req, bus.busy, bus.l2_addr, bus.core_rdata);
        end
        tick();
        rst = 1'b0;
        bus.core_req[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.l2_ack = 1'($urandom);
            tick();
            n_cmp++;
            if ({bus.core_done, bus.busy, bus.l2_req} !== {N'(0), 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_after[%0d]: got done=%b busy=%b req=%b required all 0", k, bus.core_done, bus.busy, bus.l2_req);
            end
        end
        bus.l2_ack = 1'b0;
    endtask

`ifdef L2_TIMEOUT_EN
    task automatic test_timeout();
        int cnt;
        bus.core_req[2]  = 1'b1;
        bus.core_we[2]   = 1'b0;
        bus.core_addr[2] = 32'h0000_0500;
        bus.grant        = 2'd2;
        bus.grant_ready  = 1'b1;
        tick();
        bus.grant_ready  = 1'b0;
        cnt = 0;
        while (bus.l2_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        exp_rdata = '0;
        n_cmp++;
        if ({32'(cnt), bus.core_done, bus.core_err, bus.core_rdata} !== {32'(TO), 4'b0100, 4'b0100, exp_rdata}) begin
            n_bad++;
            $display("FAIL timeout: got cycles=%0d done=%b err=%b rdata=%h required cycles=%0d done=0100 err=0100 rdata=0",
                     cnt, bus.core_done, bus.core_err, bus.core_rdata, TO);
        end
        bus.core_req[2] = 1'b0;
        tick();
        // An ack arriving on the limit cycle counts as normal completion.
        run_txn(2, 1'b1, 1'b0, 32'h0000_0504, 32'h0, TO, 32'hCAFE_F00D, "ack_at_limit");
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_stale_grant();
        test_back_to_back();
        test_arbiter_loop();
        test_reset_mid();
`ifdef L2_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
